// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO with status flags.
package sync_fifo_pkg;

    // Read-side behaviour: registered head (STD) or head shown combinationally (FWFT).
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Pointers carry one extra wrap bit above the storage index.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous
// read port, and no reset so the array maps onto plain distributed memory.
module fifo_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
    input  logic [DATA_WIDTH-1:0]      i_wr_data,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
    output logic [DATA_WIDTH-1:0]      o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Store the incoming word at the write index on an accepted write.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with full/empty/almost flags, occupancy count and sticky
// overflow/underflow indicators. The read side is either registered (STD) or
// first-word-fall-through (FWFT), selected at elaboration by MODE.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         DEPTH      = 16,
    parameter fifo_mode_e MODE       = FIFO_STD,
    parameter int         AFULL_TH   = DEPTH - 2,
    parameter int         AEMPTY_TH  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      w_en,
    input  logic                      r_en,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      err_clr,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    localparam logic [PW-1:0] C_PTR_ONE = PW'(1);
    localparam logic [PW-1:0] C_AFULL   = PW'(AFULL_TH);
    localparam logic [PW-1:0] C_AEMPTY  = PW'(AEMPTY_TH);

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic [PW-1:0]         w_count;
    logic [DATA_WIDTH-1:0] w_head;

    // Equal pointers mean empty; equal index with opposite wrap bit means full.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // A read never rides on a same-cycle write into an empty FIFO, but a write
    // into a full FIFO is fine when a read frees a slot on the same edge.
    assign w_rd_acc = r_en && !w_empty;
    assign w_wr_acc = w_en && (!w_full || w_rd_acc);

    // Modular subtraction yields the occupancy directly, including across wrap.
    assign w_count = r_wr_ptr - r_rd_ptr;

    fifo_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_regfile (
        .clk        (clk),
        .i_wr_en    (w_wr_acc),
        .i_wr_addr  (r_wr_ptr[AW-1:0]),
        .i_wr_data  (data_in),
        .i_rd_addr  (r_rd_ptr[AW-1:0]),
        .o_rd_data  (w_head)
    );

    // Advance the write pointer on every accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
        end else if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        end
    end

    // Advance the read pointer on every accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
        end else if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        end
    end

    // Sticky error flags: a rejection in this cycle wins over a clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_en && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (r_en && !w_rd_acc) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (MODE == FIFO_STD) begin : g_std
            logic [DATA_WIDTH-1:0] r_data_out;

            // Capture the head on an accepted read; hold otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data_out <= '0;
                end else if (w_rd_acc) begin
                    r_data_out <= w_head;
                end
            end

            assign data_out = r_data_out;
        end else begin : g_fwft
            // The head is visible as soon as it is stored; zero when empty so
            // never-written storage never reaches the output.
            assign data_out = w_empty ? '0 : w_head;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = w_count;
    assign almost_full  = (w_count >= C_AFULL);
    assign almost_empty = (w_count <= C_AEMPTY);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
